command_fetcher: RTL and testbench

Per-core GPU-side consumer of the CPU command mailbox. It sits on the GPU port of one core's mailbox memory, polls the doorbell word, claims the mailbox by setting the busy flag, fetches up to COMMAND_COUNT commands, and hands them to the core on a valid/ready interface. When the core reports idle, it writes a completion count and clears busy so the CPU sees the core as free. One instance per core, clocked by `gpu_clk`.

---
 rtl/command_fetcher_if.sv | 35 +++
 rtl/command_fetcher.sv | 194 +++++++++++++++++++
 tb/tb_command_fetcher.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/command_fetcher_if.sv
// Mailbox memory port plus core command handshake for one command_fetcher.
// The master side is the fetcher; the slave side is the memory and core.
interface command_fetcher_if #(
    parameter int BYTES_PER_WORD    = 4,
    parameter int COMMAND_COUNT     = 4,
    parameter int BYTES_PER_COMMAND = 12
);
    localparam int WORD_BITS      = 8 * BYTES_PER_WORD;
    localparam int CAPACITY_BYTES = 12 + BYTES_PER_COMMAND * COMMAND_COUNT;
    localparam int AW             = $clog2(CAPACITY_BYTES);
    localparam int IW             = (COMMAND_COUNT > 1) ? $clog2(COMMAND_COUNT) : 1;

    logic [AW-1:0]                  mem_address;
    logic [WORD_BITS-1:0]           mem_rd_data;
    logic [WORD_BITS-1:0]           mem_wr_data;
    logic [BYTES_PER_WORD-1:0]      mem_wr_en;
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [8*BYTES_PER_COMMAND-1:0] cmd_data;
    logic [IW-1:0]                  cmd_index;
    logic                           core_idle;
    logic                           busy;

    modport master (
        output mem_address, mem_wr_data, mem_wr_en,
        output cmd_valid, cmd_data, cmd_index, busy,
        input  mem_rd_data, cmd_ready, core_idle
    );

    modport slave (
        input  mem_address, mem_wr_data, mem_wr_en,
        input  cmd_valid, cmd_data, cmd_index, busy,
        output mem_rd_data, cmd_ready, core_idle
    );
endinterface

// File: rtl/command_fetcher.sv
// GPU-side consumer of one core's command mailbox: polls the doorbell, claims
// the mailbox, fetches up to COMMAND_COUNT commands, hands them to the core,
// then posts a completion count and releases the mailbox.
// All outputs are registered: the comb logic computes next state/counters and
// the outputs that belong to that next state, which the flops then present.
module command_fetcher #(
    parameter int BYTES_PER_WORD    = 4,
    parameter int COMMAND_COUNT     = 4,
    parameter int BYTES_PER_COMMAND = 12
) (
    input  logic                gpu_clk,
    input  logic                gpu_reset_n,
    command_fetcher_if.master   bus
);
    localparam int WORD_BITS      = 8 * BYTES_PER_WORD;
    localparam int CAPACITY_BYTES = 12 + BYTES_PER_COMMAND * COMMAND_COUNT;
    localparam int AW             = $clog2(CAPACITY_BYTES);
    localparam int IW             = (COMMAND_COUNT > 1) ? $clog2(COMMAND_COUNT) : 1;
    localparam int WPC            = BYTES_PER_COMMAND / BYTES_PER_WORD;
    localparam int WW             = $clog2(WPC + 1);
    localparam int NW             = $clog2(COMMAND_COUNT + 1);

    typedef enum logic [3:0] {
        S_INIT, S_POLL_ADDR, S_POLL_CHK, S_CLAIM, S_CLEAR,
        S_FETCH, S_ISSUE, S_DRAIN, S_DONE, S_RELEASE
    } state_t;

    state_t                          state_r, state_s;
    logic                            init_wr_r;
    logic [NW-1:0]                   n_r, n_s;
    logic [IW-1:0]                   k_r, k_s;
    logic [WW-1:0]                   w_r, w_s;
    logic [AW-1:0]                   addr_r, addr_s;
    logic [WORD_BITS-1:0]            wr_data_r, wr_data_s;
    logic [BYTES_PER_WORD-1:0]       wr_en_r, wr_en_s;
    logic                            valid_r;
    logic [8*BYTES_PER_COMMAND-1:0]  data_r;
    logic [IW-1:0]                   index_r;
    logic                            busy_r;

    // Next-state and batch counter logic.
    always_comb begin
        state_s = state_r;
        n_s     = n_r;
        k_s     = k_r;
        w_s     = w_r;
        case (state_r)
            // First INIT cycle only schedules the status clear; the second performs it.
            S_INIT: begin
                if (init_wr_r) begin
                    state_s = S_POLL_ADDR;
                end else begin
                    state_s = S_INIT;
                end
            end
            S_POLL_ADDR: state_s = S_POLL_CHK;
            S_POLL_CHK: begin
                if (bus.mem_rd_data == {WORD_BITS{1'b0}}) begin
                    state_s = S_POLL_ADDR;
                end else begin
                    if (bus.mem_rd_data > WORD_BITS'(COMMAND_COUNT)) begin
                        n_s = NW'(COMMAND_COUNT);
                    end else begin
                        n_s = NW'(bus.mem_rd_data);
                    end
                    k_s     = {IW{1'b0}};
                    state_s = S_CLAIM;
                end
            end
            S_CLAIM: state_s = S_CLEAR;
            S_CLEAR: begin
                w_s     = {WW{1'b0}};
                state_s = S_FETCH;
            end
            // One extra FETCH cycle after the last address absorbs the read latency.
            S_FETCH: begin
                if (w_r == WW'(WPC)) begin
                    state_s = S_ISSUE;
                end else begin
                    w_s = w_r + WW'(1);
                end
            end
            S_ISSUE: begin
                if (bus.cmd_ready) begin
                    if ((NW'(k_r) + NW'(1)) < n_r) begin
                        k_s     = k_r + IW'(1);
                        w_s     = {WW{1'b0}};
                        state_s = S_FETCH;
                    end else begin
                        state_s = S_DRAIN;
                    end
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (bus.core_idle) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE:    state_s = S_RELEASE;
            S_RELEASE: state_s = S_POLL_ADDR;
            default:   state_s = S_INIT;
        endcase
    end

    // Memory port values belonging to the state being entered.
    always_comb begin
        addr_s    = {AW{1'b0}};
        wr_data_s = {WORD_BITS{1'b0}};
        wr_en_s   = {BYTES_PER_WORD{1'b0}};
        case (state_s)
            S_INIT: begin
                wr_en_s = {BYTES_PER_WORD{1'b1}};
            end
            S_POLL_ADDR: begin
                addr_s = AW'(4);
            end
            S_CLAIM: begin
                wr_en_s   = {BYTES_PER_WORD{1'b1}};
                wr_data_s = WORD_BITS'(1);
            end
            S_CLEAR: begin
                wr_en_s = {BYTES_PER_WORD{1'b1}};
                addr_s  = AW'(4);
            end
            S_FETCH: begin
                if (w_s < WW'(WPC)) begin
                    addr_s = AW'(12 + BYTES_PER_COMMAND * int'(k_s) + BYTES_PER_WORD * int'(w_s));
                end else begin
                    addr_s = {AW{1'b0}};
                end
            end
            S_DONE: begin
                wr_en_s   = {BYTES_PER_WORD{1'b1}};
                addr_s    = AW'(8);
                wr_data_s = WORD_BITS'(n_s);
            end
            S_RELEASE: begin
                wr_en_s = {BYTES_PER_WORD{1'b1}};
            end
            default: begin
                addr_s = {AW{1'b0}};
            end
        endcase
    end

    // State, counters, registered outputs and command word capture.
    always_ff @(posedge gpu_clk or negedge gpu_reset_n) begin
        if (!gpu_reset_n) begin
            state_r   <= S_INIT;
            init_wr_r <= 1'b0;
            n_r       <= {NW{1'b0}};
            k_r       <= {IW{1'b0}};
            w_r       <= {WW{1'b0}};
            addr_r    <= {AW{1'b0}};
            wr_data_r <= {WORD_BITS{1'b0}};
            wr_en_r   <= {BYTES_PER_WORD{1'b0}};
            valid_r   <= 1'b0;
            data_r    <= {(8*BYTES_PER_COMMAND){1'b0}};
            index_r   <= {IW{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            init_wr_r <= 1'b1;
            n_r       <= n_s;
            k_r       <= k_s;
            w_r       <= w_s;
            addr_r    <= addr_s;
            wr_data_r <= wr_data_s;
            wr_en_r   <= wr_en_s;
            valid_r   <= (state_s == S_ISSUE);
            index_r   <= k_s;
            if (state_r == S_FETCH && w_r != {WW{1'b0}}) begin
                data_r[WORD_BITS*(int'(w_r)-1) +: WORD_BITS] <= bus.mem_rd_data;
            end
            if (state_r == S_CLAIM) begin
                busy_r <= 1'b1;
            end else if (state_r == S_RELEASE) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign bus.mem_address = addr_r;
    assign bus.mem_wr_data = wr_data_r;
    assign bus.mem_wr_en   = wr_en_r;
    assign bus.cmd_valid   = valid_r;
    assign bus.cmd_data    = data_r;
    assign bus.cmd_index   = index_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_command_fetcher.sv
// Directed bench for command_fetcher: a small mailbox memory model, a CPU write
// port into it, and logs of GPU writes and command handshakes with cycle stamps.
module tb_command_fetcher;
    logic gpu_clk = 1'b0;
    logic gpu_reset_n = 1'b0;

    command_fetcher_if #(.BYTES_PER_WORD(4), .COMMAND_COUNT(4), .BYTES_PER_COMMAND(12)) bus();

    command_fetcher #(.BYTES_PER_WORD(4), .COMMAND_COUNT(4), .BYTES_PER_COMMAND(12)) dut (
        .gpu_clk     (gpu_clk),
        .gpu_reset_n (gpu_reset_n),
        .bus         (bus)
    );

    always #5 gpu_clk = ~gpu_clk;

    typedef struct packed { int cyc; logic [5:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { int cyc; logic [1:0] idx; logic [95:0] data; } hs_t;

    logic [31:0] mem [0:15];
    logic        cpu_we = 1'b0;
    logic [3:0]  cpu_addr = 4'd0;
    logic [31:0] cpu_data = 32'd0;
    int          cyc = 0;
    wr_t         wlog[$];
    hs_t         hlog[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    // Mailbox memory: CPU write first so a same-cycle GPU write wins.
    always @(posedge gpu_clk) begin
        if (cpu_we) mem[cpu_addr] <= cpu_data;
        if (bus.mem_wr_en == 4'hF) mem[bus.mem_address[5:2]] <= bus.mem_wr_data;
        bus.mem_rd_data <= mem[bus.mem_address[5:2]];
    end

    // Logs GPU writes and handshakes stamped with the cycle they occurred in.
    always @(posedge gpu_clk) begin
        if (bus.mem_wr_en == 4'hF) wlog.push_back('{cyc, bus.mem_address, bus.mem_wr_data});
        if (bus.cmd_valid && bus.cmd_ready) hlog.push_back('{cyc, bus.cmd_index, bus.cmd_data});
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge gpu_clk);
        cpu_we = 1'b1; cpu_addr = a; cpu_data = d;
        @(negedge gpu_clk);
        cpu_we = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge gpu_clk);
    endtask

    function automatic logic [95:0] cmd_word3(input int k);
        logic [31:0] w0, w1, w2;
        w0 = 32'hC0DE_0000 | (32'd3 + 32'd3 * k[31:0]);
        w1 = w0 + 32'd1;
        w2 = w0 + 32'd2;
        return {w2, w1, w0};
    endfunction

    initial begin
        int n4, n0, same;
        logic [5:0] prev;
        int d;
        bus.cmd_ready = 1'b0;
        bus.core_idle = 1'b1;

        // Reset state and memory clear
        for (int i = 0; i < 16; i++) cpu_write(i[3:0], 32'd0);
        #1;
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_wren", bus.mem_wr_en, 0);
        chk("rst_valid", bus.cmd_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_data", bus.cmd_data, 0);

        // Test 1: idle polling with doorbell 0
        wlog.delete(); hlog.delete();
        @(negedge gpu_clk); gpu_reset_n = 1'b1;
        cycles(4);
        n4 = 0; n0 = 0; same = 0; prev = bus.mem_address;
        for (int i = 0; i < 10; i++) begin
            @(negedge gpu_clk);
            if (bus.mem_address == 6'd4) n4++;
            if (bus.mem_address == 6'd0) n0++;
            if (bus.mem_address == prev) same++;
            if (bus.cmd_valid || bus.busy) same++;
            prev = bus.mem_address;
        end
        chk("t1_poll4", n4, 5);
        chk("t1_poll0", n0, 5);
        chk("t1_alternate", same, 0);
        chk("t1_nwrites", wlog.size(), 1);
        chk("t1_initwr", {wlog[0].addr, wlog[0].data}, {6'd0, 32'd0});

        // Test 2: two commands, ready and idle tied high
        cpu_write(4'd3, 32'hA000_0000); cpu_write(4'd4, 32'hA000_0001); cpu_write(4'd5, 32'hA000_0002);
        cpu_write(4'd6, 32'hB000_0000); cpu_write(4'd7, 32'hB000_0001); cpu_write(4'd8, 32'hB000_0002);
        bus.cmd_ready = 1'b1;
        wlog.delete(); hlog.delete();
        cpu_write(4'd1, 32'd2);
        for (int i = 0; i < 50 && wlog.size() < 1; i++) @(negedge gpu_clk);
        chk("t2_claim_seen", wlog.size() >= 1, 1);
        chk("t2_busy_set", bus.busy, 1);
        for (int i = 0; i < 100 && wlog.size() < 4; i++) @(negedge gpu_clk);
        cycles(2);
        chk("t2_nwrites", wlog.size(), 4);
        chk("t2_nhs", hlog.size(), 2);
        chk("t2_wr0", {wlog[0].addr, wlog[0].data}, {6'd0, 32'd1});
        chk("t2_wr1", {wlog[1].addr, wlog[1].data, 32'(wlog[1].cyc - wlog[0].cyc)}, {6'd4, 32'd0, 32'd1});
        chk("t2_hs0_lat", hlog[0].cyc - wlog[0].cyc, 6);
        chk("t2_hs0", {hlog[0].idx, hlog[0].data}, {2'd0, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
        chk("t2_hs1_lat", hlog[1].cyc - hlog[0].cyc, 5);
        chk("t2_hs1", {hlog[1].idx, hlog[1].data}, {2'd1, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000});
        chk("t2_done", {wlog[2].addr, wlog[2].data, 32'(wlog[2].cyc - hlog[1].cyc)}, {6'd8, 32'd2, 32'd2});
        chk("t2_release", {wlog[3].addr, wlog[3].data, 32'(wlog[3].cyc - wlog[2].cyc)}, {6'd0, 32'd0, 32'd1});
        chk("t2_busy_clr", bus.busy, 0);

        // Test 3: doorbell 7 clamps to four commands
        for (int i = 3; i < 15; i++) cpu_write(i[3:0], 32'hC0DE_0000 | i[31:0]);
        wlog.delete(); hlog.delete();
        cpu_write(4'd1, 32'd7);
        for (int i = 0; i < 300 && wlog.size() < 4; i++) @(negedge gpu_clk);
        cycles(10);
        chk("t3_nhs", hlog.size(), 4);
        chk("t3_hs3", {hlog[3].idx, hlog[3].data}, {2'd3, cmd_word3(3)});
        chk("t3_hs1", {hlog[1].idx, hlog[1].data}, {2'd1, cmd_word3(1)});
        chk("t3_done", {wlog[2].addr, wlog[2].data}, {6'd8, 32'd4});

        // Test 4: cmd_ready held low for 10 cycles
        bus.cmd_ready = 1'b0;
        wlog.delete(); hlog.delete();
        cpu_write(4'd1, 32'd1);
        for (int i = 0; i < 50 && !bus.cmd_valid; i++) @(negedge gpu_clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t4_hold%0d", i), {bus.cmd_valid, bus.cmd_index, bus.cmd_data}, {1'b1, 2'd0, cmd_word3(0)});
            if (i < 9) @(negedge gpu_clk);
        end
        bus.cmd_ready = 1'b1;
        @(negedge gpu_clk);
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 50 && wlog.size() < 4; i++) @(negedge gpu_clk);
        cycles(3);
        chk("t4_nhs", hlog.size(), 1);
        chk("t4_done", {wlog[2].addr, wlog[2].data}, {6'd8, 32'd1});

        // Test 5: core_idle held low after the last handshake
        bus.cmd_ready = 1'b1;
        bus.core_idle = 1'b0;
        wlog.delete(); hlog.delete();
        cpu_write(4'd1, 32'd1);
        for (int i = 0; i < 50 && hlog.size() < 1; i++) @(negedge gpu_clk);
        cycles(20);
        chk("t5_nowrite", wlog.size(), 2);
        chk("t5_busy_held", bus.busy, 1);
        d = cyc;
        bus.core_idle = 1'b1;
        for (int i = 0; i < 20 && wlog.size() < 4; i++) @(negedge gpu_clk);
        chk("t5_done", {wlog[2].addr, wlog[2].data, 32'(wlog[2].cyc)}, {6'd8, 32'd1, 32'(d + 1)});
        chk("t5_release", {wlog[3].addr, wlog[3].data, 32'(wlog[3].cyc)}, {6'd0, 32'd0, 32'(d + 2)});

        // Test 6: reset during FETCH of command 1 of 3
        cycles(3);
        wlog.delete(); hlog.delete();
        cpu_write(4'd1, 32'd3);
        for (int i = 0; i < 50 && hlog.size() < 1; i++) @(negedge gpu_clk);
        @(negedge gpu_clk);
        gpu_reset_n = 1'b0;
        #1;
        chk("t6_rst_out", {bus.cmd_valid, bus.busy, bus.mem_wr_en, bus.mem_address, bus.mem_wr_data},
            {1'b0, 1'b0, 4'd0, 6'd0, 32'd0});
        chk("t6_rst_data", {bus.cmd_data, bus.cmd_index}, {96'd0, 2'd0});
        cycles(3);
        wlog.delete(); hlog.delete();
        gpu_reset_n = 1'b1;
        cycles(30);
        chk("t6_nwrites", wlog.size(), 1);
        chk("t6_initwr", {wlog[0].addr, wlog[0].data}, {6'd0, 32'd0});
        chk("t6_nhs", hlog.size(), 0);
        chk("t6_status", mem[0], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
